// File: rtl/jt51_sh_tap.sv
`default_nettype none
// ============================================================================
//  Module   : jt51_sh_tap
//  Purpose  : Random-access reader for a 2**slotw-slot time-multiplexed
//             stream (operator pipeline shift registers).
//             - Follows the slot position using a slot-0 sync strobe.
//             - Captures the word present on the requested slot.
//             - Returns that word over a valid/ready handshake.
//  Ports    : clk, rst_n       - clock, asynchronous active-low reset
//             cen              - clock enable, stream advances one slot per cen
//             sync             - slot 0 present on din this cen cycle
//             din              - stream word
//             req, slot        - read request and requested slot index
//             busy             - a request is outstanding
//             dout_valid/ready - handshake for the captured word
//             dout             - captured word
//             desync           - sticky: sync seen off the expected slot
//  Revision : 1.0 - initial release
// ============================================================================
module jt51_sh_tap #(
  parameter int width = 14,
  parameter int slotw = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             sync,
  input  logic [width-1:0] din,
  input  logic             req,
  input  logic [slotw-1:0] slot,
  output logic             busy,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [width-1:0] dout,
  output logic             desync
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [slotw-1:0] cnt;
  logic             locked;
  logic [slotw-1:0] target;

  logic [slotw-1:0] cur;
  logic             aligned;
  logic             accept;
  logic             capture;
  logic             desync_set;

  // Slot on din this cycle: the strobe itself marks slot 0.
  assign cur = sync ? '0 : cnt;

  // The strobe establishes alignment on its own cycle, so a slot-0 request
  // armed before the first sync captures on that very strobe edge.
  assign aligned = locked | sync;

  assign desync_set = cen & sync & locked & (cnt != '0);

  // --------------------------------------------------------------------------
  // Slot tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      locked <= 1'b0;
    end else if (cen) begin
      if (sync) begin
        cnt    <= slotw'(1);
        locked <= 1'b1;
      end else begin
        cnt    <= cnt + slotw'(1);   // natural wrap at 2**slotw-1
      end
    end
  end

  // --------------------------------------------------------------------------
  // Request FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Request FSM: next state and strobes
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          accept    = 1'b1;
          state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (cen && aligned && (cur == target)) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (dout_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy       = (state != S_IDLE);
  assign dout_valid = (state == S_HOLD);

  // --------------------------------------------------------------------------
  // Datapath: target latch, capture register, sticky desync flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= '0;
      dout   <= '0;
    end else begin
      if (accept) begin
        target <= slot;
      end
      if (capture) begin
        dout <= din;
      end
    end
  end

  // A new misalignment on the accepting edge takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      desync <= 1'b0;
    end else if (desync_set) begin
      desync <= 1'b1;
    end else if (accept) begin
      desync <= 1'b0;
    end
  end

endmodule
`default_nettype wire
